updown_mod_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, and selectable wrap or saturate behaviour. It succeeds the fixed 8-bit toggle-driven ripple counter as the team's general-purpose counting block. It supports any width, any terminal value, both directions, and a one-shot (halt-at-terminal) mode for timers and event counters in the Exe-series circuits.

---
 rtl/updown_mod_counter_if.sv | 33 +++
 rtl/updown_mod_counter.sv | 64 ++++++
 tb/tb_updown_mod_counter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
//   toggle   : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : synchronous parallel load of data_in
//   data_in  : load value (clamped to MAX by the counter)
//   saturate : 0 = wrap at terminal, 1 = halt at terminal
//   count    : registered count
//   tc       : combinational terminal-count flag
//   wrap     : registered one-cycle wrap pulse
//   halted   : registered sticky halt flag
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             toggle;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             saturate;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             halted;

    modport master (
        output toggle, up, load, data_in, saturate,
        input  count, tc, wrap, halted
    );

    modport slave (
        input  toggle, up, load, data_in, saturate,
        output count, tc, wrap, halted
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MAX with parallel load and wrap/saturate modes.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : control inputs and count/tc/wrap/halted outputs (slave side)
module updown_mod_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 2**WIDTH - 1
) (
    input  logic                 clock,
    input  logic                 reset,
    updown_mod_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             halted_q, halted_d;
    logic [WIDTH-1:0] term_c;
    logic             at_term_c;
    logic [WIDTH-1:0] load_val_c;

    // Terminal value depends on the direction currently requested.
    assign term_c     = bus.up ? MAX_V : '0;
    assign at_term_c  = (count_q == term_c);
    assign load_val_c = (bus.data_in > MAX_V) ? MAX_V : bus.data_in;

    // Next-state: load beats toggle beats hold; halted only clears on load.
    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        halted_d = halted_q;
        if (bus.load) begin
            count_d  = load_val_c;
            halted_d = 1'b0;
        end else if (bus.toggle && !halted_q) begin
            if (!at_term_c) begin
                count_d = bus.up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
            end else if (!bus.saturate) begin
                count_d = bus.up ? '0 : MAX_V;
                wrap_d  = 1'b1;
            end else begin
                halted_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            halted_q <= halted_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.wrap   = wrap_q;
    assign bus.halted = halted_q;
    assign bus.tc     = at_term_c;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: a WIDTH=8/MAX=255 instance for reset behaviour and a
// WIDTH=4/MAX=9 instance for counting, wrap, saturate, load and hold.
module tb_updown_mod_counter;
    localparam int unsigned M = 9;

    typedef struct {
        int unsigned count;
        bit          wrap;
        bit          halted;
    } exp_t;

    logic clock;
    logic rst8;
    logic rst4;

    int unsigned checks;
    int unsigned failures;

    exp_t sb[$];

    // Reference state for the MAX=9 instance.
    int unsigned m_count;
    bit          m_wrap;
    bit          m_halt;

    updown_mod_counter_if #(.WIDTH(8)) bus8 ();
    updown_mod_counter_if #(.WIDTH(4)) bus4 ();

    updown_mod_counter #(.WIDTH(8), .MAX(255)) u_dut8 (
        .clock (clock),
        .reset (rst8),
        .bus   (bus8)
    );

    updown_mod_counter #(.WIDTH(4), .MAX(M)) u_dut4 (
        .clock (clock),
        .reset (rst4),
        .bus   (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle on the MAX=9 instance, predict, then compare.
    task automatic drive(input bit ld, input bit tg, input bit u, input bit sat,
                         input int unsigned din, input string tag);
        exp_t e;
        int unsigned t;
        bus4.load     = ld;
        bus4.toggle   = tg;
        bus4.up       = u;
        bus4.saturate = sat;
        bus4.data_in  = 4'(din);
        t = u ? M : 0;
        if (ld) begin
            m_count = (din > M) ? M : din;
            m_halt  = 1'b0;
            m_wrap  = 1'b0;
        end else if (tg && !m_halt) begin
            m_wrap = 1'b0;
            if (m_count != t) begin
                m_count = u ? m_count + 1 : m_count - 1;
            end else if (!sat) begin
                m_count = u ? 0 : M;
                m_wrap  = 1'b1;
            end else begin
                m_halt = 1'b1;
            end
        end else begin
            m_wrap = 1'b0;
        end
        e.count  = m_count;
        e.wrap   = m_wrap;
        e.halted = m_halt;
        sb.push_back(e);
        tick();
        check({tag, "_sb_avail"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_count"},  bus4.count,  e.count);
            check({tag, "_wrap"},   bus4.wrap,   e.wrap);
            check({tag, "_halted"}, bus4.halted, e.halted);
            check({tag, "_tc"},     bus4.tc,     (e.count == (u ? M : 0)) ? 1 : 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_count  = 0;
        m_wrap   = 0;
        m_halt   = 0;
        rst8 = 1'b0;
        rst4 = 1'b0;
        bus8.toggle = 0; bus8.up = 1; bus8.load = 0; bus8.data_in = '0; bus8.saturate = 0;
        bus4.toggle = 0; bus4.up = 1; bus4.load = 0; bus4.data_in = '0; bus4.saturate = 0;
        #12;
        check("rst4_count", bus4.count, 0);
        check("rst4_wrap", bus4.wrap, 0);
        check("rst4_halted", bus4.halted, 0);
        check("rst4_tc_up", bus4.tc, 0);
        bus4.up = 0;
        #1;
        check("rst4_tc_down", bus4.tc, 1);
        bus4.up = 1;
        tick();
        rst8 = 1'b1;
        rst4 = 1'b1;

        // Reset mid-operation on the 8-bit instance.
        bus8.toggle = 1;
        bus8.up     = 1;
        repeat (5) tick();
        check("rst8_pre_count", bus8.count, 5);
        #2;
        rst8 = 1'b0;
        #1;
        check("rst8_async_count", bus8.count, 0);
        check("rst8_async_wrap", bus8.wrap, 0);
        check("rst8_async_halted", bus8.halted, 0);
        bus8.up = 0;
        #1;
        check("rst8_tc_down", bus8.tc, 1);
        bus8.toggle = 0;

        // Up wrap 0..9 -> 0.
        drive(1, 0, 1, 0, 0, "upw_load");
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, 0, "upw");
            check("upw_seq", bus4.count, (i + 1) % 10);
            check("upw_wrap_seq", bus4.wrap, (i == 9) ? 1 : 0);
        end
        drive(0, 0, 1, 0, 0, "upw_after");
        check("upw_wrap_one_cycle", bus4.wrap, 0);

        // Down wrap then direction change.
        drive(1, 0, 0, 0, 2, "dn_load");
        drive(0, 1, 0, 0, 0, "dn1");
        check("dn1_const", bus4.count, 1);
        drive(0, 1, 0, 0, 0, "dn0");
        check("dn0_const", bus4.count, 0);
        drive(0, 1, 0, 0, 0, "dn9");
        check("dn9_const", bus4.count, 9);
        check("dn9_wrap_const", bus4.wrap, 1);
        drive(0, 1, 1, 0, 0, "dir_up");
        check("dir_up_const", bus4.count, 0);
        check("dir_up_wrap_const", bus4.wrap, 1);

        // Saturate: halts at 9, direction change does not release.
        drive(1, 0, 1, 1, 8, "sat_load");
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 1, 0, "sat");
            check("sat_count_const", bus4.count, 9);
            check("sat_halted_const", bus4.halted, (i >= 1) ? 1 : 0);
        end
        drive(0, 1, 0, 0, 0, "sat_dirchg");
        check("sat_still_halted", bus4.halted, 1);
        drive(1, 0, 1, 1, 3, "sat_reload");
        check("sat_reload_const", bus4.count, 3);
        check("sat_reload_halt", bus4.halted, 0);

        // Load priority over toggle, with clamp.
        drive(1, 1, 1, 0, 12, "ld_clamp");
        check("ld_clamp_const", bus4.count, 9);
        drive(1, 1, 1, 0, 4, "ld_prio");
        check("ld_prio_const", bus4.count, 4);

        // Hold with random up/saturate.
        drive(1, 0, 1, 0, 6, "hold_load");
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1'($urandom), 1'($urandom), 0, "hold");
            check("hold_const", bus4.count, 6);
        end

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 15), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
